// File: rtl/bilinear_wr_packer.sv
// bilinear_wr_packer
//   Packs the N-lane byte write stream of the bilinear downscale core into
//   32-bit word writes with byte strobes, buffers them in a small FIFO and
//   drains that FIFO to a word-wide memory write port. The input side never
//   back-pressures: beats that cannot be absorbed are dropped and flagged.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      [N]     per-lane byte valid (must be 2^m-1 when non-zero)
//   in_addr       [N*32]  per-lane byte address, lane k at [32k+31:32k]
//   in_data       [N*8]   per-lane byte, lane k at [8k+7:8k]
//   flush         pulse: emit the partial word once pending input is done
//   clear         pulse: clear overflow, err and word_count
//   mem_wvalid    FIFO head valid
//   mem_wready    memory accepts the head word
//   mem_waddr     word-aligned byte address of the head word
//   mem_wdata     little-endian head word data
//   mem_wstrb     head word byte strobes
//   idle          FIFO empty, no partial word, no flush pending
//   overflow      sticky: a beat was dropped for lack of FIFO room
//   err           sticky: a beat broke the lane contract and was dropped
//   word_count    number of words accepted by memory (wraps)

module bilinear_wr_packer #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*32-1:0] in_addr,
  input  logic [N*8-1:0]  in_data,
  input  logic            flush,
  input  logic            clear,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [31:0]     mem_waddr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic            idle,
  output logic            overflow,
  output logic            err,
  output logic [31:0]     word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  entry_t          acc;
  logic            acc_valid;
  logic            flush_pend;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          out_e;

  logic            beat;
  logic            contig;
  logic            lane_bad;
  logic            legal;
  logic [29:0]     wa;
  logic [29:0]     wb;
  entry_t          wa_e;
  entry_t          wb_e;
  entry_t          cur;
  logic            cur_v;
  logic [1:0]      c_np;
  entry_t          c_p0;
  entry_t          c_p1;

  logic [CW-1:0]   free_slots;
  logic [1:0]      push_n;
  entry_t          push0;
  entry_t          push1;
  entry_t          acc_n;
  logic            acc_v_n;
  logic            set_err;
  logic            set_ovf;
  logic            flush_exec;
  logic            pop;
  logic [CW-1:0]   count_n;
  logic [CW-1:0]   after_pop;

  // Lane contract check, split of the beat into its first (WA) and possibly
  // second (WB) word, and the trial merge into the accumulator. The trial
  // result is only committed later if the beat is legal and fits.
  always_comb begin
    beat     = |in_valid;
    contig   = ((in_valid & (in_valid + N'(1))) == '0);
    lane_bad = 1'b0;
    wa       = in_addr[31:2];
    wb       = in_addr[31:2];
    wa_e     = '0;
    wb_e     = '0;
    cur      = acc;
    cur_v    = acc_valid;
    c_np     = 2'd0;
    c_p0     = '0;
    c_p1     = '0;

    for (int k = 1; k < N; k++) begin
      if (in_valid[k] &&
          (in_addr[32*k +: 32] != in_addr[32*(k-1) +: 32] + 32'd1))
        lane_bad = 1'b1;
    end
    legal = beat && contig && !lane_bad;

    // The highest valid lane carries the last address of the beat.
    for (int k = 0; k < N; k++) begin
      if (in_valid[k])
        wb = in_addr[32*k+2 +: 30];
    end

    wa_e.word = wa;
    wb_e.word = wb;
    for (int k = 0; k < N; k++) begin
      if (in_valid[k]) begin
        if (in_addr[32*k+2 +: 30] == wa) begin
          wa_e.data[8*int'(in_addr[32*k +: 2]) +: 8] = in_data[8*k +: 8];
          wa_e.strb[in_addr[32*k +: 2]]              = 1'b1;
        end else begin
          wb_e.data[8*int'(in_addr[32*k +: 2]) +: 8] = in_data[8*k +: 8];
          wb_e.strb[in_addr[32*k +: 2]]              = 1'b1;
        end
      end
    end

    // A partial word for a different address is retired first.
    if (cur_v && (cur.word != wa)) begin
      c_p0  = cur;
      c_np  = 2'd1;
      cur_v = 1'b0;
    end

    if (!cur_v) begin
      cur      = '0;
      cur.word = wa;
    end
    for (int b = 0; b < 4; b++) begin
      if (wa_e.strb[b])
        cur.data[8*b +: 8] = wa_e.data[8*b +: 8];
    end
    cur.strb = cur.strb | wa_e.strb;
    cur_v    = 1'b1;

    // A beat straddling a word boundary closes the first word.
    if (wb != wa) begin
      if (c_np == 2'd0) c_p0 = cur;
      else              c_p1 = cur;
      c_np = c_np + 2'd1;
      cur  = wb_e;
    end

    if (cur.strb == 4'hF) begin
      if (c_np == 2'd0) c_p0 = cur;
      else              c_p1 = cur;
      c_np  = c_np + 2'd1;
      cur_v = 1'b0;
    end
  end

  // Commit decision. Room is judged on the occupancy at the start of the
  // cycle, so a pop happening in the same cycle does not create room.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    push_n     = 2'd0;
    push0      = c_p0;
    push1      = c_p1;
    acc_n      = acc;
    acc_v_n    = acc_valid;
    set_err    = 1'b0;
    set_ovf    = 1'b0;
    flush_exec = 1'b0;

    if (beat) begin
      if (!legal) begin
        set_err = 1'b1;
      end else if (CW'(c_np) > free_slots) begin
        set_ovf = 1'b1;
      end else begin
        push_n  = c_np;
        acc_n   = cur;
        acc_v_n = cur_v;
      end
    end else if (flush_pend && (free_slots != '0)) begin
      flush_exec = 1'b1;
      if (acc_valid) begin
        push_n = 2'd1;
        push0  = acc;
      end
      acc_n   = '0;
      acc_v_n = 1'b0;
    end
  end

  assign mem_wvalid = (count != '0);
  assign pop        = mem_wvalid && mem_wready;
  assign count_n    = count + CW'(push_n) - CW'(pop);
  assign after_pop  = count - CW'(pop);

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0)
      mem[wr_ptr] <= push0;
    if (push_n == 2'd2)
      mem[wr_ptr + AW'(1)] <= push1;
  end

  // Pointers, accumulator, status and the registered head word. When the
  // FIFO would otherwise be empty after this cycle's pop, the new head is the
  // first word being pushed now; otherwise it is already in storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_e      <= '0;
      acc        <= '0;
      acc_valid  <= 1'b0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count_n;
      if (count_n != '0) begin
        if (after_pop == '0)
          out_e <= push0;
        else
          out_e <= mem[rd_ptr + AW'(pop)];
      end
      acc        <= acc_n;
      acc_valid  <= acc_v_n;
      flush_pend <= (flush_pend && !flush_exec) || flush;
      overflow   <= (overflow && !clear) || set_ovf;
      err        <= (err && !clear) || set_err;
      if (clear)
        word_count <= '0;
      else if (pop)
        word_count <= word_count + 32'd1;
    end
  end

  assign mem_waddr = {out_e.word, 2'b00};
  assign mem_wdata = out_e.data;
  assign mem_wstrb = out_e.strb;
  assign idle      = (count == '0) && !acc_valid && !flush_pend;

endmodule

// File: tb/tb_bilinear_wr_packer.sv
// tb_bilinear_wr_packer
//   Directed bench for bilinear_wr_packer (N=4, DEPTH=8). Each step drives
//   one cycle of input and compares the outputs 1 ns after the clock edge
//   against hand-computed values.

module tb_bilinear_wr_packer;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*32-1:0] in_addr;
  logic [N*8-1:0]  in_data;
  logic            flush;
  logic            clear;
  logic            mem_wvalid;
  logic            mem_wready;
  logic [31:0]     mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            idle;
  logic            overflow;
  logic            err;
  logic [31:0]     word_count;

  int checks = 0;
  int errors = 0;

  bilinear_wr_packer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .flush      (flush),
    .clear      (clear),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .idle       (idle),
    .overflow   (overflow),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Consecutive byte addresses starting at base, one per lane.
  function automatic logic [N*32-1:0] lanes(input logic [31:0] base);
    logic [N*32-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of input, then return the input to quiet.
  task automatic applyStimulus(input logic [N-1:0]    v,
                               input logic [N*32-1:0] a,
                               input logic [N*8-1:0]  d,
                               input logic            fl);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    flush    = fl;
    tick();
    in_valid = '0;
    in_addr  = '0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic checkOutput(input string       tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    in_addr    = '0;
    in_data    = '0;
    flush      = 1'b0;
    clear      = 1'b0;
    mem_wready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("rst_waddr",  mem_waddr,       32'h0);
    checkOutput("rst_wdata",  mem_wdata,       32'h0);
    checkOutput("rst_wstrb",  32'(mem_wstrb),  32'h0);
    checkOutput("rst_idle",   32'(idle),       32'd1);
    checkOutput("rst_ovf",    32'(overflow),   32'd0);
    checkOutput("rst_err",    32'(err),        32'd0);
    checkOutput("rst_wcnt",   word_count,      32'd0);

    $display("[TB] aligned beat");
    applyStimulus(4'hF, lanes(32'h100), 32'h44332211, 1'b0);
    checkOutput("al_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("al_waddr",  mem_waddr,       32'h100);
    checkOutput("al_wdata",  mem_wdata,       32'h44332211);
    checkOutput("al_wstrb",  32'(mem_wstrb),  32'hF);
    checkOutput("al_idle",   32'(idle),       32'd0);
    mem_wready = 1'b1;
    tick();
    checkOutput("al_wvalid_after", 32'(mem_wvalid), 32'd0);
    checkOutput("al_wcnt",         word_count,      32'd1);
    checkOutput("al_idle_after",   32'(idle),       32'd1);

    $display("[TB] unaligned beats");
    applyStimulus(4'hF, lanes(32'h102), 32'hDDCCBBAA, 1'b0);
    checkOutput("un1_waddr", mem_waddr,      32'h100);
    checkOutput("un1_wdata", mem_wdata,      32'hBBAA0000);
    checkOutput("un1_wstrb", 32'(mem_wstrb), 32'hC);
    applyStimulus(4'hF, lanes(32'h106), 32'h44332211, 1'b0);
    checkOutput("un2_waddr", mem_waddr,      32'h104);
    checkOutput("un2_wdata", mem_wdata,      32'h2211DDCC);
    checkOutput("un2_wstrb", 32'(mem_wstrb), 32'hF);
    checkOutput("un2_wcnt",  word_count,     32'd2);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("un3_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("un3_wcnt",   word_count,      32'd3);
    checkOutput("un3_idle",   32'(idle),       32'd0);
    tick();
    checkOutput("unf_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("unf_waddr",  mem_waddr,       32'h108);
    checkOutput("unf_wdata",  mem_wdata,       32'h00004433);
    checkOutput("unf_wstrb",  32'(mem_wstrb),  32'h3);
    tick();
    checkOutput("und_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("und_wcnt",   word_count,      32'd4);
    checkOutput("und_idle",   32'(idle),       32'd1);

    $display("[TB] back-pressure and overflow");
    mem_wready = 1'b0;
    for (int i = 0; i < 9; i++)
      applyStimulus(4'hF, lanes(32'h1000 + 32'(4*i)), 32'hA5000000 + 32'(i), 1'b0);
    checkOutput("bp_ovf",    32'(overflow),   32'd1);
    checkOutput("bp_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("bp_waddr",  mem_waddr,       32'h1000);
    checkOutput("bp_wdata",  mem_wdata,       32'hA5000000);
    mem_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("bp_drain_waddr", mem_waddr, 32'h1000 + 32'(4*i));
      checkOutput("bp_drain_wdata", mem_wdata, 32'hA5000000 + 32'(i));
      tick();
    end
    checkOutput("bp_end_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("bp_end_wcnt",   word_count,      32'd12);
    checkOutput("bp_end_idle",   32'(idle),       32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_ovf",  32'(overflow), 32'd0);
    checkOutput("clr_wcnt", word_count,    32'd0);

    $display("[TB] lane contract violations");
    applyStimulus(4'b0001, lanes(32'h300), 32'h000000EE, 1'b0);
    checkOutput("cv0_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("cv0_err",    32'(err),        32'd0);
    applyStimulus(4'b0101, lanes(32'h301), 32'h99999999, 1'b0);
    checkOutput("cv1_err",    32'(err),        32'd1);
    checkOutput("cv1_wvalid", 32'(mem_wvalid), 32'd0);
    applyStimulus(4'hF, {32'h14, 32'h13, 32'h11, 32'h10}, 32'h99999999, 1'b0);
    checkOutput("cv2_err",    32'(err),        32'd1);
    checkOutput("cv2_wvalid", 32'(mem_wvalid), 32'd0);
    applyStimulus(4'b0111, lanes(32'h301), 32'h00332211, 1'b0);
    checkOutput("cv3_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("cv3_waddr",  mem_waddr,       32'h300);
    checkOutput("cv3_wdata",  mem_wdata,       32'h332211EE);
    checkOutput("cv3_wstrb",  32'(mem_wstrb),  32'hF);
    tick();
    checkOutput("cv3_wcnt", word_count, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("cv_clr_err",  32'(err),  32'd0);
    checkOutput("cv_clr_wcnt", word_count, 32'd0);

    $display("[TB] flush together with a beat");
    applyStimulus(4'b0011, lanes(32'h200), 32'h0000BBAA, 1'b1);
    checkOutput("fb_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("fb_idle",   32'(idle),       32'd0);
    tick();
    checkOutput("fb_push_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("fb_push_waddr",  mem_waddr,       32'h200);
    checkOutput("fb_push_wdata",  mem_wdata,       32'h0000BBAA);
    checkOutput("fb_push_wstrb",  32'(mem_wstrb),  32'h3);
    tick();
    checkOutput("fb_end_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("fb_end_wcnt",   word_count,      32'd1);
    checkOutput("fb_end_idle",   32'(idle),       32'd1);

    $display("[TB] reset mid-drain");
    mem_wready = 1'b0;
    applyStimulus(4'hF, lanes(32'h400), 32'h03020100, 1'b0);
    applyStimulus(4'hF, lanes(32'h404), 32'h07060504, 1'b0);
    applyStimulus(4'hF, lanes(32'h408), 32'h0B0A0908, 1'b0);
    applyStimulus(4'b0001, lanes(32'h500), 32'h00000077, 1'b0);
    checkOutput("rm_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("rm_waddr",  mem_waddr,       32'h400);
    checkOutput("rm_idle",   32'(idle),       32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rm_rst_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("rm_rst_idle",   32'(idle),       32'd1);
    checkOutput("rm_rst_wcnt",   word_count,      32'd0);
    checkOutput("rm_rst_waddr",  mem_waddr,       32'h0);
    mem_wready = 1'b1;
    tick();
    tick();
    checkOutput("rm_quiet_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("rm_quiet_wcnt",   word_count,      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
